// File: rtl/dbg_bus_arbiter.sv
// Debug bus arbiter: two masters (JTAG bridge, on-chip requester) share one
// debug unit slave port. Round-robin on ties. A request that has been
// presented but not granted keeps the port. An in-order ID FIFO steers each
// response back to the master that issued it.
module dbg_bus_arbiter #(
  parameter int ADDR_WIDTH      = 15,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,

  output logic                  s_req,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_we,
  output logic [31:0]           s_wdata,
  input  logic                  s_gnt,
  input  logic                  s_rvalid,
  input  logic [31:0]           s_rdata
);

  localparam int PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CntW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  // Open: free arbitration. LockM0/LockM1: that master was presented to the
  // slave without a grant and must keep the port until it is accepted.
  typedef enum logic [1:0] {
    ARB_OPEN    = 2'd0,
    ARB_LOCK_M0 = 2'd1,
    ARB_LOCK_M1 = 2'd2
  } arbState_e;

  arbState_e state_q, state_d;
  logic      rrLast_q, rrLast_d;

  logic [MAX_OUTSTANDING-1:0] idMem_q;
  logic [PtrW-1:0]            wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]            rdPtr_q, rdPtr_d;
  logic [CntW-1:0]            count_q, count_d;

  logic sel;
  logic selReq;
  logic fifoFull;
  logic fifoEmpty;
  logic accept;
  logic rspFwd;
  logic headId;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
    if (ptr == LastPtr) begin
      nextPtr = '0;
    end else begin
      nextPtr = ptr + PtrW'(1);
    end
  endfunction

  // Pick the master that owns the slave port this cycle and derive the lock state for the next one.
  always_comb begin
    state_d = state_q;
    sel     = 1'b0;

    case (state_q)
      ARB_LOCK_M0: sel = 1'b0;
      ARB_LOCK_M1: sel = 1'b1;
      default: begin
        if (m0_req && m1_req) begin
          sel = ~rrLast_q;
        end else if (m1_req) begin
          sel = 1'b1;
        end else begin
          sel = 1'b0;
        end
      end
    endcase

    if (s_req && s_gnt) begin
      state_d = ARB_OPEN;
    end else if (s_req) begin
      state_d = sel ? ARB_LOCK_M1 : ARB_LOCK_M0;
    end
  end

  assign selReq    = sel ? m1_req : m0_req;
  assign fifoFull  = (count_q == MaxCnt);
  assign fifoEmpty = (count_q == '0);
  assign headId    = idMem_q[rdPtr_q];

  assign s_req  = rst_n && selReq && !fifoFull;
  assign accept = s_req && s_gnt;
  assign rspFwd = rst_n && s_rvalid && !fifoEmpty;

  // Steer the selected master's command onto the slave port; master 0 when idle.
  always_comb begin
    s_addr  = m0_addr;
    s_we    = m0_we;
    s_wdata = m0_wdata;
    if (sel) begin
      s_addr  = m1_addr;
      s_we    = m1_we;
      s_wdata = m1_wdata;
    end
  end

  assign m0_gnt    = accept && !sel;
  assign m1_gnt    = accept && sel;
  assign m0_rvalid = rspFwd && !headId;
  assign m1_rvalid = rspFwd && headId;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  // The round-robin pointer only moves when a transaction is actually accepted.
  always_comb begin
    rrLast_d = rrLast_q;
    if (accept) begin
      rrLast_d = sel;
    end
  end

  // Response ID FIFO bookkeeping: push on accept, pop on a forwarded response.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (accept) begin
      wrPtr_d = nextPtr(wrPtr_q);
    end
    if (rspFwd) begin
      rdPtr_d = nextPtr(rdPtr_q);
    end
    case ({accept, rspFwd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Arbitration state registers; master 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_OPEN;
      rrLast_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      rrLast_q <= rrLast_d;
    end
  end

  // FIFO storage and pointers; reset discards every outstanding response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idMem_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        idMem_q[wrPtr_q] <= sel;
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // A response with nothing outstanding is a slave protocol error; it is dropped.
  always @(posedge clk) begin
    if (rst_n && s_rvalid) begin
      assert (count_q != '0)
        else $warning("dbg_bus_arbiter: stray s_rvalid with no outstanding transaction, response dropped");
    end
  end

endmodule
